// File: rtl/axi4lite_regbank_if.sv
// axi4lite_intf: AXI4-Lite link bundle (32-bit address, 32-bit data).
// Ports (per modport):
//   master - drives AW/W/AR payload+valid and bready/rready; receives readies and B/R.
//   slave  - the mirror image of master.
// Carries no clock or reset; those stay plain ports on the attached modules.
interface axi4lite_intf;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4lite_regbank.sv
// axi4lite_regbank: AXI4-Lite slave exposing NUM_REGS 32-bit registers.
// Registers flagged in RO_MASK are read-only and return status_i; the rest are
// read/write control registers with byte-strobe writes.
// Ports:
//   aclk, aresetn - clock, asynchronous active-low reset
//   s_axi         - AXI4-Lite slave port (awprot/arprot unused)
//   reg_o         - RW register contents, word i at [i*32 +: 32]; RO slots read 0
//   wr_pulse_o    - one-cycle strobe per register on a successful write commit
//   status_i      - RO register sources, word i at [i*32 +: 32], sampled at AR handshake
module axi4lite_regbank #(
    parameter int unsigned         NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axi4lite_intf.slave               s_axi,
    output logic [NUM_REGS*32-1:0]    reg_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o,
    input  logic [NUM_REGS*32-1:0]    status_i
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                ready_en;

    // Write engine state
    logic                aw_full;
    logic [31:0]         aw_addr;
    logic                w_full;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic [NUM_REGS-1:0] wr_pulse_q;
    logic [31:0]         regs [NUM_REGS];

    // Read engine state
    logic                rvalid_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;

    logic [IDX_W-1:0]    aw_idx;
    logic                aw_oor;
    logic                wr_ok;
    logic [IDX_W-1:0]    ar_idx;
    logic                ar_oor;
    logic [31:0]         status_w [NUM_REGS];
    logic                unused_bits;

    always_comb begin
        aw_idx = aw_addr[2 +: IDX_W];
        aw_oor = |aw_addr[31:IDX_W+2];
        wr_ok  = ~aw_oor & ~RO_MASK[aw_idx];
        ar_idx = s_axi.araddr[2 +: IDX_W];
        ar_oor = |s_axi.araddr[31:IDX_W+2];
    end

    always_comb begin
        s_axi.awready = ready_en & ~aw_full & ~bvalid_q;
        s_axi.wready  = ready_en & ~w_full & ~bvalid_q;
        s_axi.bvalid  = bvalid_q;
        s_axi.bresp   = bresp_q;
        s_axi.arready = ready_en & ~rvalid_q;
        s_axi.rvalid  = rvalid_q;
        s_axi.rdata   = rdata_q;
        s_axi.rresp   = rresp_q;
        wr_pulse_o    = wr_pulse_q;
    end

    always_comb begin
        reg_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            status_w[i] = status_i[i*32 +: 32];
            if (!RO_MASK[i]) begin
                reg_o[i*32 +: 32] = regs[i];
            end
        end
    end

    always_comb begin
        unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
    end

    // Readies open one edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full    <= 1'b0;
            aw_addr    <= '0;
            w_full     <= 1'b0;
            w_data     <= '0;
            w_strb     <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse_q <= '0;
            if (s_axi.awvalid && s_axi.awready) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.awaddr;
            end
            if (s_axi.wvalid && s_axi.wready) begin
                w_full <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
            // Both readies are low while both halves are held, so the commit
            // never races a new capture.
            if (aw_full && w_full) begin
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                bvalid_q <= 1'b1;
                if (wr_ok) begin
                    bresp_q            <= RESP_OKAY;
                    wr_pulse_q[aw_idx] <= 1'b1;
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (w_strb[k]) begin
                            regs[aw_idx][k*8 +: 8] <= w_data[k*8 +: 8];
                        end
                    end
                end else begin
                    bresp_q <= RESP_SLVERR;
                end
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Reads sample regs before any same-edge commit lands, giving the pre-write value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (s_axi.arvalid && s_axi.arready) begin
                rvalid_q <= 1'b1;
                if (ar_oor) begin
                    rdata_q <= '0;
                    rresp_q <= RESP_SLVERR;
                end else if (RO_MASK[ar_idx]) begin
                    rdata_q <= status_w[ar_idx];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= regs[ar_idx];
                    rresp_q <= RESP_OKAY;
                end
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4lite_regbank.sv
// tb_axi4lite_regbank: directed bench for axi4lite_regbank (16 regs, reg 5 read-only).
// A vector table drives single reads/writes; hand-written sequences cover
// reset ramp, W-before-AW, B backpressure, mid-transaction reset,
// read/write collision and random ready backpressure.
module tb_axi4lite_regbank;
    localparam int unsigned N = 16;

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic [N*32-1:0]     reg_o;
    logic [N-1:0]        wr_pulse;
    logic [N*32-1:0]     status;

    int checks = 0;
    int errors = 0;

    axi4lite_intf bus ();

    axi4lite_regbank #(
        .NUM_REGS (N),
        .RO_MASK  (16'h0020)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_axi      (bus),
        .reg_o      (reg_o),
        .wr_pulse_o (wr_pulse),
        .status_i   (status)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] rword(input int unsigned i);
        return reg_o[i*32 +: 32];
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [N-1:0] pulse, output int lat);
        bit got, aw_hs, w_hs;
        got = 0; lat = 0; resp = 2'b11; pulse = '0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            if (bus.bvalid) begin
                resp = bus.bresp; pulse = wr_pulse; got = 1;
            end else begin
                lat++;
            end
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid = 1'b0;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("write_b_seen", 64'(got), 64'd1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        bit got, ar_hs;
        got = 0; lat = 0; data = 32'hxxxxxxxx; resp = 2'b11;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            if (bus.rvalid) begin
                data = bus.rdata; resp = bus.rresp; got = 1;
            end else begin
                lat++;
            end
            ar_hs = bus.arvalid && bus.arready;
            tick();
            if (ar_hs) bus.arvalid = 1'b0;
        end
        bus.arvalid = 1'b0;
        check("read_r_seen", 64'(got), 64'd1);
    endtask

    task automatic bp_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] er);
        bit done, aw_hs, w_hs;
        done = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            if (bus.bvalid) check("bp_bresp", 64'(bus.bresp), 64'(er));
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            done  = bus.bvalid && bus.bready;
            tick();
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs)  bus.wvalid = 1'b0;
            bus.bready = 1'($urandom_range(0, 1));
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        check("bp_write_done", 64'(done), 64'd1);
    endtask

    task automatic bp_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        bit done, ar_hs;
        done = 0;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
        for (int n = 0; n < 80 && !done; n++) begin
            if (bus.rvalid) begin
                check("bp_rdata", 64'(bus.rdata), 64'(ed));
                check("bp_rresp", 64'(bus.rresp), 64'(er));
            end
            ar_hs = bus.arvalid && bus.arready;
            done  = bus.rvalid && bus.rready;
            tick();
            if (ar_hs) bus.arvalid = 1'b0;
            bus.rready = 1'($urandom_range(0, 1));
        end
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        check("bp_read_done", 64'(done), 64'd1);
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [N-1:0] exp_pulse;
        int          reg_idx;   // write: reg_o word to inspect
        logic [31:0] exp_val;   // write: reg_o word; read: rdata
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [1:0]   resp;
        logic [N-1:0] pulse;
        logic [31:0]  data;
        logic [31:0]  model2;
        int           lat;

        vecs[0]  = '{1'b1, 32'h0000000C, 32'hDEADBEEF, 4'hF, 2'b00, 16'h0008, 3,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h0000000C, 32'h0,        4'h0, 2'b00, 16'h0000, 0,  32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h00000014, 32'h12345678, 4'hF, 2'b10, 16'h0000, 5,  32'h00000000};
        vecs[3]  = '{1'b1, 32'h00000040, 32'h12345678, 4'hF, 2'b10, 16'h0000, 0,  32'h00000000};
        vecs[4]  = '{1'b0, 32'h00000040, 32'h0,        4'h0, 2'b10, 16'h0000, 0,  32'h00000000};
        vecs[5]  = '{1'b0, 32'h00000014, 32'h0,        4'h0, 2'b00, 16'h0000, 0,  32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 32'h00000000, 32'h12345678, 4'h3, 2'b00, 16'h0001, 0,  32'h00005678};
        vecs[7]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 4'h0, 2'b00, 16'h0001, 0,  32'h00005678};
        vecs[8]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 2'b00, 16'h0000, 0,  32'h00005678};
        vecs[9]  = '{1'b1, 32'h0000003F, 32'hAABBCCDD, 4'hF, 2'b00, 16'h8000, 15, 32'hAABBCCDD};
        vecs[10] = '{1'b0, 32'h0000003E, 32'h0,        4'h0, 2'b00, 16'h0000, 0,  32'hAABBCCDD};
        vecs[11] = '{1'b0, 32'h10000014, 32'h0,        4'h0, 2'b10, 16'h0000, 0,  32'h00000000};

        status = '0;
        for (int i = 0; i < 16; i++) status[i*32 +: 32] = 32'hBAD00000 | 32'(i);
        status[5*32 +: 32] = 32'hA5A5A5A5;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Reset state and ready ramp
        repeat (3) tick();
        check("rst_awready", 64'(bus.awready), 64'd0);
        check("rst_arready", 64'(bus.arready), 64'd0);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_rdata",   64'(bus.rdata),   64'd0);
        check("rst_reg_o",   64'(|reg_o),      64'd0);
        check("rst_pulse",   64'(wr_pulse),    64'd0);
        aresetn = 1'b1;
        #1;
        check("ramp_c1_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
        tick();
        check("ramp_c2_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'd7);

        // Table-driven single transactions
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, resp, pulse, lat);
                check($sformatf("v%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_resp));
                check($sformatf("v%0d_pulse", i), 64'(pulse), 64'(vecs[i].exp_pulse));
                check($sformatf("v%0d_wlat", i), 64'(lat), 64'd2);
                check($sformatf("v%0d_reg", i), 64'(rword(vecs[i].reg_idx)), 64'(vecs[i].exp_val));
                check($sformatf("v%0d_pulse_end", i), 64'(wr_pulse), 64'd0);
            end else begin
                do_read(vecs[i].addr, data, resp, lat);
                check($sformatf("v%0d_rdata", i), 64'(data), 64'(vecs[i].exp_val));
                check($sformatf("v%0d_rresp", i), 64'(resp), 64'(vecs[i].exp_resp));
                check($sformatf("v%0d_rlat", i), 64'(lat), 64'd1);
            end
        end

        // W before AW, partial strobe, B held off for 5 cycles
        bus.bready = 1'b0;
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("wfirst_wready", 64'(bus.wready), 64'd0);
        check("wfirst_awready", 64'(bus.awready), 64'd1);
        repeat (2) tick();
        check("wfirst_no_b", 64'(bus.bvalid), 64'd0);
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wfirst_held_aw", 64'(bus.awready), 64'd0);
        tick();
        check("wfirst_bvalid", 64'(bus.bvalid), 64'd1);
        check("wfirst_pulse", 64'(wr_pulse), 64'h0008);
        check("wfirst_reg3", 64'(rword(3)), 64'hDE22BE44);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bhold_bvalid", 64'(bus.bvalid), 64'd1);
            check("bhold_bresp", 64'(bus.bresp), 64'd0);
            check("bhold_readies", 64'({bus.awready, bus.wready}), 64'd0);
            check("bhold_pulse", 64'(wr_pulse), 64'd0);
        end
        bus.bready = 1'b1;
        tick();
        check("b_done_bvalid", 64'(bus.bvalid), 64'd0);
        check("b_done_readies", 64'({bus.awready, bus.wready}), 64'd3);

        // Mid-transaction reset: AW accepted, W never sent
        bus.awaddr = 32'h0C; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("mid_aw_held", 64'(bus.awready), 64'd0);
        aresetn = 1'b0;
        #1;
        check("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
        check("mid_rst_reg_o", 64'(|reg_o), 64'd0);
        check("mid_rst_pulse", 64'(wr_pulse), 64'd0);
        check("mid_rst_wready", 64'(bus.wready), 64'd0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("mid_ramp_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'd7);
        do_write(32'h04, 32'hCAFEF00D, 4'hF, resp, pulse, lat);
        check("mid_fresh_bresp", 64'(resp), 64'd0);
        check("mid_fresh_pulse", 64'(pulse), 64'h0002);
        check("mid_fresh_reg1", 64'(rword(1)), 64'hCAFEF00D);
        check("mid_fresh_reg3", 64'(rword(3)), 64'd0);

        // Read of reg 3 on the same edge its write commits sees the old value
        bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0; bus.rready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.araddr = 32'h0C; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("coll_rvalid", 64'(bus.rvalid), 64'd1);
        check("coll_rdata", 64'(bus.rdata), 64'd0);
        check("coll_bvalid", 64'(bus.bvalid), 64'd1);
        check("coll_reg3", 64'(rword(3)), 64'h55);
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        do_read(32'h0C, data, resp, lat);
        check("coll_reread", 64'(data), 64'h55);

        // Random backpressure on B and R
        model2 = 32'h0;
        for (int t = 0; t < 4; t++) begin
            data = $urandom;
            bp_write(32'h08, data, 2'b00);
            model2 = data;
            bp_read(32'h08, model2, 2'b00);
        end
        bp_write(32'h14, 32'h01020304, 2'b10);
        bp_read(32'h44, 32'h0, 2'b10);
        bp_read(32'h14, 32'hA5A5A5A5, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
